// File: rtl/vortex_mem_responder_pkg.sv
// Shared types for the Vortex line-granular memory responder: line/address/tag
// typedefs, the response entry carried through the read pipe and FIFO, and line decode.
package vortex_mem_responder_pkg;

    localparam int unsigned MEM_DATA_WIDTH   = 512;
    localparam int unsigned MEM_ADDR_WIDTH   = 26;
    localparam int unsigned MEM_TAG_WIDTH    = 56;
    localparam int unsigned MEM_BYTEEN_WIDTH = MEM_DATA_WIDTH / 8;

    typedef logic [MEM_DATA_WIDTH-1:0]   line_t;
    typedef logic [MEM_ADDR_WIDTH-1:0]   addr_t;
    typedef logic [MEM_TAG_WIDTH-1:0]    tag_t;
    typedef logic [MEM_BYTEEN_WIDTH-1:0] byteen_t;

    typedef struct packed {
        line_t data;
        tag_t  tag;
    } rsp_entry_t;

    typedef struct packed {
        logic  in_range;
        addr_t index;
    } line_loc_t;

    // Offset from the RAM base with MAW-bit wrap; only the low depth_bits index the RAM.
    function automatic line_loc_t line_index(input addr_t addr, input addr_t base,
                                             input int unsigned depth_bits);
        line_loc_t loc;
        loc.index    = addr - base;
        loc.in_range = (loc.index >> depth_bits) == '0;
        return loc;
    endfunction

endpackage

// File: rtl/vortex_mem_responder_if.sv
// Vortex memory request/response channel; master is the core side, slave the memory.
interface vortex_mem_responder_if;
    import vortex_mem_responder_pkg::*;

    logic    mem_req_valid;
    logic    mem_req_rw;
    byteen_t mem_req_byteen;
    addr_t   mem_req_addr;
    line_t   mem_req_data;
    tag_t    mem_req_tag;
    logic    mem_req_ready;

    logic    mem_rsp_valid;
    line_t   mem_rsp_data;
    tag_t    mem_rsp_tag;
    logic    mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );

endinterface

// File: rtl/vx_rsp_fifo.sv
// First-word-fall-through response FIFO; pointers carry one wrap bit to tell full from empty.
module vx_rsp_fifo
    import vortex_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  rsp_entry_t             entry_i,
    input  logic                   pop_i,
    output rsp_entry_t             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    rsp_entry_t   mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, rd_ptr_q;

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[PW-1:0]] <= entry_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/vortex_mem_responder.sv
// Line RAM responder for the Vortex memory interface with fixed-latency tagged reads.
// Optional perf counters are built when VX_MEM_RESPONDER_PERF_EN is defined.
module vortex_mem_responder
    import vortex_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_BITS     = 9,
    parameter addr_t       BASE_LINE_ADDR = 26'h200_0000,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    vortex_mem_responder_if.slave mem,
    input  logic                  host_wen,
    input  logic [DEPTH_BITS+3:0] host_addr,
    input  logic [31:0]           host_wdata,
    input  logic [3:0]            host_strobe
`ifdef VX_MEM_RESPONDER_PERF_EN
    ,
    output logic [31:0]           perf_reads,
    output logic [31:0]           perf_writes,
    output logic [31:0]           perf_rsp_stall
`endif
);

    localparam int unsigned LINES = 1 << DEPTH_BITS;
    localparam int unsigned CW    = $clog2(RSP_FIFO_DEPTH) + 1;

    line_t                 ram [LINES];
    line_loc_t             req_loc;
    logic [DEPTH_BITS-1:0] req_idx;
    logic                  unused_idx_hi;
    logic [DEPTH_BITS-1:0] host_line;
    logic [3:0]            host_word;
    logic                  wr_accept, rd_accept, rsp_pop;
    rsp_entry_t            rd_entry;
    rsp_entry_t            pipe_q [LATENCY];
    logic [LATENCY-1:0]    pipe_vld_q;
    logic [CW-1:0]         credit_q, credit_d;
    rsp_entry_t            fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;

    assign req_loc       = line_index(mem.mem_req_addr, BASE_LINE_ADDR, DEPTH_BITS);
    assign req_idx       = req_loc.index[DEPTH_BITS-1:0];
    assign unused_idx_hi = ^req_loc.index[MEM_ADDR_WIDTH-1:DEPTH_BITS];
    assign host_line     = host_addr[DEPTH_BITS+3:4];
    assign host_word     = host_addr[3:0];

    // Credits cover in-flight plus queued reads, so the pipe can never overrun the FIFO.
    assign mem.mem_req_ready = !reset && !host_wen && (credit_q < CW'(RSP_FIFO_DEPTH));
    assign wr_accept = mem.mem_req_valid && mem.mem_req_ready && mem.mem_req_rw;
    assign rd_accept = mem.mem_req_valid && mem.mem_req_ready && !mem.mem_req_rw;
    assign rsp_pop   = mem.mem_rsp_valid && mem.mem_rsp_ready;

    always_ff @(posedge clk) begin
        if (host_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (host_strobe[b]) ram[host_line][{host_word, 2'(b), 3'b000} +: 8] <= host_wdata[8*b +: 8];
            end
        end else if (wr_accept && req_loc.in_range) begin
            for (int b = 0; b < MEM_BYTEEN_WIDTH; b++) begin
                if (mem.mem_req_byteen[b]) ram[req_idx][8*b +: 8] <= mem.mem_req_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_entry.tag  = mem.mem_req_tag;
        rd_entry.data = req_loc.in_range ? ram[req_idx] : '0;
    end

    // Stage 0 samples the RAM at the accept edge; LATENCY-1 more stages follow.
    always_ff @(posedge clk) begin
        pipe_q[0] <= rd_entry;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            credit_q   <= '0;
        end else begin
            pipe_vld_q[0] <= rd_accept;
            for (int i = 1; i < LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
            credit_q <= credit_d;
        end
    end

    // NOTE: credit_d gets its default first so every path assigns it and no latch is inferred.
    always_comb begin
        credit_d = credit_q;
        if (rd_accept && !rsp_pop)      credit_d = credit_q + 1'b1;
        else if (!rd_accept && rsp_pop) credit_d = credit_q - 1'b1;
    end

    vx_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pipe_vld_q[LATENCY-1]),
        .entry_i (pipe_q[LATENCY-1]),
        .pop_i   (rsp_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem.mem_rsp_valid = !fifo_empty;
    assign mem.mem_rsp_data  = fifo_empty ? '0 : fifo_head.data;
    assign mem.mem_rsp_tag   = fifo_empty ? '0 : fifo_head.tag;

    assert property (@(posedge clk) disable iff (reset) !(pipe_vld_q[LATENCY-1] && fifo_full));
    assert property (@(posedge clk) disable iff (reset) credit_q >= fifo_count);

`ifdef VX_MEM_RESPONDER_PERF_EN
    logic [31:0] perf_reads_q, perf_writes_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (rd_accept && perf_reads_q != '1)  perf_reads_q  <= perf_reads_q + 1'b1;
            if (wr_accept && perf_writes_q != '1) perf_writes_q <= perf_writes_q + 1'b1;
            if (mem.mem_rsp_valid && !mem.mem_rsp_ready && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_reads     = perf_reads_q;
    assign perf_writes    = perf_writes_q;
    assign perf_rsp_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_vortex_mem_responder.sv
// Bench for vortex_mem_responder: directed vector table, hand-written credit/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_vortex_mem_responder;
    import vortex_mem_responder_pkg::*;

    localparam int unsigned LAT  = 2;
    localparam addr_t       BASE = 26'h200_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_wen;
    logic [12:0] host_addr;
    logic [31:0] host_wdata;
    logic [3:0]  host_strobe;

    vortex_mem_responder_if mem_if();

`ifdef VX_MEM_RESPONDER_PERF_EN
    logic [31:0] perf_reads, perf_writes, perf_rsp_stall;
`endif

    vortex_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (mem_if),
        .host_wen    (host_wen),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_strobe (host_strobe)
`ifdef VX_MEM_RESPONDER_PERF_EN
        ,
        .perf_reads     (perf_reads),
        .perf_writes    (perf_writes),
        .perf_rsp_stall (perf_rsp_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic    rw;
        byteen_t be;
        addr_t   addr;
        line_t   data;
        tag_t    tag;
        line_t   exp;
    } vec_t;

    // Issue one request; for reads, wait for the response and check latency, data and tag.
    task automatic do_op(input vec_t v);
        int n;
        int lat;
        mem_if.mem_req_valid  = 1'b1;
        mem_if.mem_req_rw     = v.rw;
        mem_if.mem_req_byteen = v.be;
        mem_if.mem_req_addr   = v.addr;
        mem_if.mem_req_data   = v.data;
        mem_if.mem_req_tag    = v.tag;
        mem_if.mem_rsp_ready  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_if.mem_req_ready && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("op_req_ready", mem_if.mem_req_ready, 1);
        tick();
        mem_if.mem_req_valid = 1'b0;
        if (!v.rw) begin
            lat = 0;
            @(negedge clk);
            while (!mem_if.mem_rsp_valid && lat < 20) begin
                tick();
                @(negedge clk);
                lat++;
            end
            check("rd_latency", lat, LAT);
            check("rd_data", mem_if.mem_rsp_data, v.exp);
            check("rd_tag", mem_if.mem_rsp_tag, v.tag);
            tick();
        end
    endtask

    // Reads with rsp_ready low: exactly 4 are accepted, then in-order drain.
    task automatic fill_drain(input tag_t base_tag);
        int issued;
        issued = 0;
        mem_if.mem_rsp_ready = 1'b0;
        mem_if.mem_req_rw    = 1'b0;
        mem_if.mem_req_addr  = BASE;
        for (int c = 0; c < 10; c++) begin
            mem_if.mem_req_valid = (issued < 6);
            mem_if.mem_req_tag   = base_tag + tag_t'(issued);
            @(negedge clk);
            if (mem_if.mem_req_valid && mem_if.mem_req_ready) issued++;
            tick();
        end
        mem_if.mem_req_valid = 1'b0;
        check("fill_accepts", issued, 4);
        @(negedge clk);
        check("fill_ready_low", mem_if.mem_req_ready, 0);
        check("fill_rsp_valid", mem_if.mem_rsp_valid, 1);
        check("drain_tag0", mem_if.mem_rsp_tag, base_tag);
        mem_if.mem_rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("ready_after_pop", mem_if.mem_req_ready, 1);
        for (int i = 1; i < 4; i++) begin
            check("drain_valid", mem_if.mem_rsp_valid, 1);
            check("drain_tag", mem_if.mem_rsp_tag, base_tag + tag_t'(i));
            tick();
            @(negedge clk);
        end
        check("drain_empty", mem_if.mem_rsp_valid, 0);
        tick();
    endtask

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        line_t data;
        tag_t  tag;
        int    t;
    } exp_t;

    line_t mem_m [16];
    exp_t  exp_q [$];

    initial begin
        vec_t vecs [13];
        int   stale;
        int   cyc;
        logic exp_ready, exp_valid;
        addr_t diff;

        reset = 1'b1;
        host_wen = 1'b0; host_addr = '0; host_wdata = '0; host_strobe = '0;
        mem_if.mem_req_valid = 1'b0; mem_if.mem_req_rw = 1'b0; mem_if.mem_req_byteen = '0;
        mem_if.mem_req_addr = '0; mem_if.mem_req_data = '0; mem_if.mem_req_tag = '0;
        mem_if.mem_rsp_ready = 1'b0;

        vecs[0]  = '{1'b1, '1,        26'h200_0000, {64{8'hA5}},          '0,    '0};
        vecs[1]  = '{1'b0, '0,        26'h200_0000, '0,                   56'h11, {64{8'hA5}}};
        vecs[2]  = '{1'b1, '1,        26'h200_0000, '0,                   '0,    '0};
        vecs[3]  = '{1'b1, 64'h1,     26'h200_0000, {{63{8'hFF}}, 8'h3C}, '0,    '0};
        vecs[4]  = '{1'b0, '0,        26'h200_0000, '0,                   56'h22, 512'h3C};
        vecs[5]  = '{1'b1, '1,        26'h200_01FF, {64{8'hB7}},          '0,    '0};
        vecs[6]  = '{1'b1, '1,        26'h200_0001, '0,                   '0,    '0};
        vecs[7]  = '{1'b0, '0,        26'h1FF_FFFF, '0,                   56'h33, '0};
        vecs[8]  = '{1'b0, '0,        26'h200_0200, '0,                   56'h34, '0};
        vecs[9]  = '{1'b1, '1,        26'h200_0200, {64{8'hEE}},          '0,    '0};
        vecs[10] = '{1'b0, '0,        26'h200_0000, '0,                   56'h35, 512'h3C};
        vecs[11] = '{1'b0, '0,        26'h200_01FF, '0,                   56'h36, {64{8'hB7}}};
        vecs[12] = '{1'b0, '0,        26'h200_0001, '0,                   56'h37, '0};

        repeat (3) tick();
        @(negedge clk);
        check("reset_req_ready", mem_if.mem_req_ready, 0);
        check("reset_rsp_valid", mem_if.mem_rsp_valid, 0);
        check("reset_rsp_data", mem_if.mem_rsp_data, 0);
        check("reset_rsp_tag", mem_if.mem_rsp_tag, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", mem_if.mem_req_ready, 1);
        tick();

        for (int i = 0; i < 13; i++) do_op(vecs[i]);

        // Host write wins over a pending request and blocks ready for that cycle.
        host_wen = 1'b1; host_addr = 13'h012; host_wdata = 32'hDEAD_BEEF; host_strobe = 4'hF;
        mem_if.mem_req_valid = 1'b1; mem_if.mem_req_rw = 1'b0;
        mem_if.mem_req_addr = 26'h200_0001; mem_if.mem_req_tag = 56'h55;
        @(negedge clk);
        check("host_blocks_ready", mem_if.mem_req_ready, 0);
        tick();
        host_wen = 1'b0;
        mem_if.mem_req_valid = 1'b0;
        do_op('{1'b0, '0, 26'h200_0001, '0, 56'h56, line_t'(64'hDEAD_BEEF) << 64});

        fill_drain(56'h40);

        // Reset with reads in flight and queued.
        mem_if.mem_rsp_ready = 1'b0; mem_if.mem_req_rw = 1'b0; mem_if.mem_req_addr = BASE;
        for (int i = 0; i < 3; i++) begin
            mem_if.mem_req_valid = 1'b1;
            mem_if.mem_req_tag = 56'h60 + tag_t'(i);
            tick();
        end
        mem_if.mem_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_rsp_valid", mem_if.mem_rsp_valid, 0);
        check("mid_reset_ready", mem_if.mem_req_ready, 0);
        tick();
        @(negedge clk);
        check("mid_reset_rsp_valid2", mem_if.mem_rsp_valid, 0);
        tick();
        reset = 1'b0;
        mem_if.mem_rsp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_if.mem_rsp_valid) stale++;
            tick();
        end
        check("no_stale_rsp", stale, 0);
        fill_drain(56'h70);

        // Preload lines 0..15 from the host port for the randomized phase.
        for (int l = 0; l < 16; l++) begin
            for (int w = 0; w < 16; w++) begin
                host_wen = 1'b1; host_addr = {9'(l), 4'(w)};
                host_wdata = $urandom; host_strobe = 4'hF;
                mem_m[l][32*w +: 32] = host_wdata;
                tick();
            end
        end
        host_wen = 1'b0;

        cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            host_wen    = ($urandom_range(0, 15) == 0);
            host_addr   = {9'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            host_wdata  = $urandom;
            host_strobe = 4'($urandom);
            mem_if.mem_req_valid  = ($urandom_range(0, 3) != 0);
            mem_if.mem_req_rw     = ($urandom_range(0, 2) == 0);
            mem_if.mem_req_byteen = {$urandom, $urandom};
            mem_if.mem_req_data   = rand_line();
            mem_if.mem_req_tag    = tag_t'({$urandom, $urandom});
            if ($urandom_range(0, 7) != 0)
                mem_if.mem_req_addr = BASE + addr_t'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0)
                mem_if.mem_req_addr = BASE - addr_t'(1 + $urandom_range(0, 1000));
            else
                mem_if.mem_req_addr = BASE + addr_t'(512 + $urandom_range(0, 1000));
            mem_if.mem_rsp_ready = ($urandom_range(0, 2) != 0);

            @(negedge clk);
            exp_ready = !host_wen && (exp_q.size() < 4);
            exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].t + LAT);
            check("rnd_req_ready", mem_if.mem_req_ready, exp_ready);
            check("rnd_rsp_valid", mem_if.mem_rsp_valid, exp_valid);
            if (exp_valid) begin
                check("rnd_rsp_data", mem_if.mem_rsp_data, exp_q[0].data);
                check("rnd_rsp_tag", mem_if.mem_rsp_tag, exp_q[0].tag);
                if (mem_if.mem_rsp_ready) void'(exp_q.pop_front());
            end
            if (mem_if.mem_req_valid && exp_ready) begin
                diff = mem_if.mem_req_addr - BASE;
                if (mem_if.mem_req_rw) begin
                    if (diff < 512) begin
                        for (int b = 0; b < 64; b++)
                            if (mem_if.mem_req_byteen[b])
                                mem_m[diff[3:0]][8*b +: 8] = mem_if.mem_req_data[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back('{(diff < 512) ? mem_m[diff[3:0]] : '0, mem_if.mem_req_tag, cyc + 1});
                end
            end
            if (host_wen) begin
                for (int b = 0; b < 4; b++)
                    if (host_strobe[b])
                        mem_m[host_addr[12:4]][32*host_addr[3:0] + 8*b +: 8] = host_wdata[8*b +: 8];
            end
            @(posedge clk);
            cyc++;
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
